dm_responder: RTL and testbench

Data-memory responder for the pipelined MIPS core's M-stage data port: it answers `m_data_addr`/`m_data_wdata`/`m_data_byteen`/`m_inst_addr` with a combinational read word and clocked byte-enabled writes. Every committed store is also pushed into a small trace FIFO drained through a valid/ready port by the grader/testbench. The block replaces the behavioural DM in the testbench and sits outside `mips`, on the opposite end of its data-memory interface.

---
 rtl/dm_responder_pkg.sv | 34 +++
 rtl/dm_responder_trace_fifo.sv | 66 ++++++
 rtl/dm_responder.sv | 94 +++++++++
 tb/tb_dm_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// rtl/dm_responder_pkg.sv - shared constants, trace record layout and byte-mask helper for dm_responder
package dm_responder_pkg;

  localparam int DM_ADDR_WIDTH = 12;
  localparam int DM_TRC_DEPTH  = 8;

  localparam int TRC_BE_W     = 4;
  localparam int TRC_DATA_W   = 32;
  localparam int TRC_ADDR_W   = 32;
  localparam int TRC_PC_W     = 32;
  localparam int TRC_BE_OFS   = 0;
  localparam int TRC_DATA_OFS = TRC_BE_OFS + TRC_BE_W;
  localparam int TRC_ADDR_OFS = TRC_DATA_OFS + TRC_DATA_W;
  localparam int TRC_PC_OFS   = TRC_ADDR_OFS + TRC_ADDR_W;
  localparam int TRC_REC_W    = TRC_PC_OFS + TRC_PC_W;

  // Field order matches the offsets above: pc is the most significant field.
  typedef struct packed {
    logic [TRC_PC_W-1:0]   pc;
    logic [TRC_ADDR_W-1:0] addr;
    logic [TRC_DATA_W-1:0] data;
    logic [TRC_BE_W-1:0]   byteen;
  } trc_rec_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dm_responder_trace_fifo.sv
// rtl/dm_responder_trace_fifo.sv - synchronous store-trace FIFO with drop-on-full sticky flag
module trace_fifo #(
  parameter int WIDTH = 100,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (cnt_q == CNT_W'(DEPTH));
    empty   = (cnt_q == '0);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    do_push = push && (!full || do_pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | (push && !do_push);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;

    head_data = empty ? '0 : store_q[rd_ptr_q];
    count     = cnt_q;
    ovf       = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - M-stage data memory with combinational read, byte-enabled writes and store trace
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
  parameter int TRC_DEPTH  = DM_TRC_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  m_data_addr,
  input  logic [31:0]                  m_data_wdata,
  input  logic [3:0]                   m_data_byteen,
  input  logic [31:0]                  m_inst_addr,
  output logic [31:0]                  m_data_rdata,
  output logic                         trc_valid,
  input  logic                         trc_ready,
  output logic [31:0]                  trc_pc,
  output logic [31:0]                  trc_addr,
  output logic [31:0]                  trc_data,
  output logic [3:0]                   trc_byteen,
  output logic [$clog2(TRC_DEPTH):0]   trc_count,
  output logic                         trc_ovf,
  output logic                         addr_err
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int WORDS = 1 << IDX_W;

  logic [31:0]          mem_q [WORDS];
  logic                 addr_err_q, addr_err_d;
  logic [IDX_W-1:0]     idx;
  logic                 in_range;
  logic                 wr_en;
  logic [31:0]          old_word, new_word, mask;
  trc_rec_t             push_rec;
  logic [TRC_REC_W-1:0] head;
  logic                 fifo_full, fifo_empty;
  logic                 unused_addr_bits;

  // Sub-word selection is done in the core; the low address bits carry no meaning here.
  assign unused_addr_bits = ^{m_data_addr[1:0], fifo_full};

  always_comb begin
    idx      = m_data_addr[ADDR_WIDTH-1:2];
    in_range = (m_data_addr[31:ADDR_WIDTH] == '0);
    old_word = mem_q[idx];
    wr_en    = in_range && (m_data_byteen != 4'b0000);
    mask     = byte_mask(m_data_byteen);
    new_word = (old_word & ~mask) | (m_data_wdata & mask);

    m_data_rdata = in_range ? old_word : 32'h0;
    // Only stray writes are flagged; non-memory instructions drive junk read addresses.
    addr_err_d = addr_err_q | (!in_range && (m_data_byteen != 4'b0000));

    push_rec.pc     = m_inst_addr;
    push_rec.addr   = {{(32-ADDR_WIDTH){1'b0}}, idx, 2'b00};
    push_rec.data   = new_word;
    push_rec.byteen = m_data_byteen;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
      addr_err_q <= 1'b0;
    end else begin
      if (wr_en) mem_q[idx] <= new_word;
      addr_err_q <= addr_err_d;
    end
  end

  trace_fifo #(
    .WIDTH (TRC_REC_W),
    .DEPTH (TRC_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .resetn    (reset),
    .push      (wr_en),
    .push_data (push_rec),
    .pop       (trc_ready),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (trc_count),
    .ovf       (trc_ovf)
  );

  assign trc_valid  = !fifo_empty;
  assign trc_pc     = head[TRC_PC_OFS   +: TRC_PC_W];
  assign trc_addr   = head[TRC_ADDR_OFS +: TRC_ADDR_W];
  assign trc_data   = head[TRC_DATA_OFS +: TRC_DATA_W];
  assign trc_byteen = head[TRC_BE_OFS   +: TRC_BE_W];
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed self-checking bench for dm_responder
module tb_dm_responder;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        trc_valid;
  logic        trc_ready;
  logic [31:0] trc_pc;
  logic [31:0] trc_addr;
  logic [31:0] trc_data;
  logic [3:0]  trc_byteen;
  logic [3:0]  trc_count;
  logic        trc_ovf;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  dm_responder #(.ADDR_WIDTH(12), .TRC_DEPTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .m_data_rdata  (m_data_rdata),
    .trc_valid     (trc_valid),
    .trc_ready     (trc_ready),
    .trc_pc        (trc_pc),
    .trc_addr      (trc_addr),
    .trc_data      (trc_data),
    .trc_byteen    (trc_byteen),
    .trc_count     (trc_count),
    .trc_ovf       (trc_ovf),
    .addr_err      (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] pc);
    m_data_addr   = a;
    m_data_wdata  = wd;
    m_data_byteen = be;
    m_inst_addr   = pc;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    trc_ready = 1'b0;
    drive(32'h10, 32'h0, 4'b0000, 32'h0);
    step;
    step;
    reset = 1'b1;
    #1;

    check("rst_rdata", m_data_rdata, 32'h0);
    check("rst_valid", trc_valid, 32'h0);
    check("rst_count", trc_count, 32'h0);
    check("rst_ovf", trc_ovf, 32'h0);
    check("rst_err", addr_err, 32'h0);
    check("rst_trc_data", trc_data, 32'h0);

    drive(32'h10, 32'h1234_5678, 4'b1111, 32'h3000);
    check("sw_prewrite_rdata", m_data_rdata, 32'h0);
    step;
    drive(32'h10, 32'h0, 4'b0000, 32'h0);
    check("sw_rdata", m_data_rdata, 32'h1234_5678);
    check("sw_valid", trc_valid, 32'h1);
    check("sw_trc_pc", trc_pc, 32'h3000);
    check("sw_trc_addr", trc_addr, 32'h10);
    check("sw_trc_data", trc_data, 32'h1234_5678);
    check("sw_trc_be", trc_byteen, 32'hF);
    check("sw_count", trc_count, 32'h1);
    trc_ready = 1'b1;
    step;
    trc_ready = 1'b0;
    #1;
    check("pop_count", trc_count, 32'h0);
    check("pop_valid", trc_valid, 32'h0);

    drive(32'h12, 32'hAAAA_AAAA, 4'b0100, 32'h3004);
    step;
    drive(32'h10, 32'hBEEF_BEEF, 4'b0011, 32'h3008);
    check("sb_rdata", m_data_rdata, 32'h12AA_5678);
    step;
    drive(32'h10, 32'h0, 4'b0000, 32'h0);
    check("sh_rdata", m_data_rdata, 32'h12AA_BEEF);
    check("sub_count", trc_count, 32'h2);
    check("sb_trc_addr", trc_addr, 32'h10);
    check("sb_trc_data", trc_data, 32'h12AA_5678);
    check("sb_trc_be", trc_byteen, 32'h4);
    trc_ready = 1'b1;
    step;
    check("sh_trc_pc", trc_pc, 32'h3008);
    check("sh_trc_data", trc_data, 32'h12AA_BEEF);
    check("sh_trc_be", trc_byteen, 32'h3);
    step;
    trc_ready = 1'b0;
    #1;
    check("sub_drained", trc_count, 32'h0);

    for (int k = 0; k < 9; k++) begin
      drive(32'h100 + 32'(4*k), 32'hA000_0000 + 32'(k), 4'b1111, 32'h4000 + 32'(4*k));
      step;
    end
    drive(32'h0, 32'h0, 4'b0000, 32'h0);
    check("ovf_count", trc_count, 32'h8);
    check("ovf_flag", trc_ovf, 32'h1);
    check("ovf_head_pc", trc_pc, 32'h4000);

    drive(32'h124, 32'hA000_0009, 4'b1111, 32'h4024);
    trc_ready = 1'b1;
    #1;
    step;
    drive(32'h0, 32'h0, 4'b0000, 32'h0);
    trc_ready = 1'b0;
    #1;
    check("fullpop_count", trc_count, 32'h8);
    check("fullpop_ovf", trc_ovf, 32'h1);

    trc_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      int kk;
      kk = (j < 7) ? j + 1 : 9;
      #1;
      check($sformatf("drain%0d_data", j), trc_data, 32'hA000_0000 + 32'(kk));
      check($sformatf("drain%0d_pc", j), trc_pc, 32'h4000 + 32'(4*kk));
      step;
    end
    trc_ready = 1'b0;
    #1;
    check("drain_count", trc_count, 32'h0);
    check("drain_valid", trc_valid, 32'h0);
    drive(32'h120, 32'h0, 4'b0000, 32'h0);
    check("dropped_rec_mem", m_data_rdata, 32'hA000_0008);
    drive(32'h124, 32'h0, 4'b0000, 32'h0);
    check("fullpop_mem", m_data_rdata, 32'hA000_0009);

    drive(32'h8000_0000, 32'h0, 4'b0000, 32'h0);
    check("oor_read_rdata", m_data_rdata, 32'h0);
    step;
    check("oor_read_err", addr_err, 32'h0);
    drive(32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 32'h5000);
    check("oor_write_rdata", m_data_rdata, 32'h0);
    step;
    drive(32'h0, 32'h0, 4'b0000, 32'h0);
    check("oor_write_err", addr_err, 32'h1);
    check("oor_write_count", trc_count, 32'h0);
    check("oor_alias_mem", m_data_rdata, 32'h0);

    for (int k = 0; k < 3; k++) begin
      drive(32'h200 + 32'(4*k), 32'h5555_0000 + 32'(k), 4'b1111, 32'h6000);
      step;
    end
    drive(32'h0, 32'h0, 4'b0000, 32'h0);
    check("preq_count", trc_count, 32'h3);
    drive(32'h20C, 32'h7777_7777, 4'b1111, 32'h6010);
    reset = 1'b0;
    step;
    reset = 1'b1;
    drive(32'h20C, 32'h0, 4'b0000, 32'h0);
    check("mrst_count", trc_count, 32'h0);
    check("mrst_valid", trc_valid, 32'h0);
    check("mrst_ovf", trc_ovf, 32'h0);
    check("mrst_err", addr_err, 32'h0);
    check("mrst_inflight_mem", m_data_rdata, 32'h0);
    drive(32'h200, 32'h0, 4'b0000, 32'h0);
    check("mrst_q_mem", m_data_rdata, 32'h0);
    drive(32'h10, 32'h0, 4'b0000, 32'h0);
    check("mrst_old_mem", m_data_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
